// File: rtl/sram_dump.sv
// Streams `count` SRAM words starting at `base_addr` out of a synchronous read port
// through a 4-entry FIFO. Read issue is gated by credits so the FIFO cannot overflow.
module sram_dump #(
  parameter int LOAD_SIZE     = 16,
  parameter int MAX_LOCATIONS = 1024
) (
  input  logic                 pulse,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOAD_SIZE-1:0] base_addr,
  input  logic [LOAD_SIZE-1:0] count,
  output logic                 rd_en,
  output logic [LOAD_SIZE-1:0] rd_addr,
  input  logic [LOAD_SIZE-1:0] rd_data,
  output logic [LOAD_SIZE-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [LOAD_SIZE-1:0] remaining;
  logic [1:0]           vld_pipe;   // [0]: read strobe on the port, [1]: rd_data valid
  logic [LOAD_SIZE-1:0] fifo [4];
  logic [1:0]           wr_ptr, rd_ptr;
  logic [2:0]           occ, occ_nxt;
  logic [3:0]           used;
  logic                 push, pop, credit;
  logic                 issue_first, issue_next, done_nxt;

  assign rd_en      = vld_pipe[0];
  assign push       = vld_pipe[1];
  assign data_valid = (occ != 3'd0);
  assign data_out   = fifo[rd_ptr];
  assign pop        = data_valid & data_ready;
  assign busy       = (state != IDLE);
  assign occ_nxt    = occ + {2'b0, push} - {2'b0, pop};

  // A pop this cycle frees its slot in time for the read issued on this edge.
  assign used   = {1'b0, occ} + {3'b0, vld_pipe[0]} + {3'b0, vld_pipe[1]};
  assign credit = used < (pop ? 4'd5 : 4'd4);

  always_comb begin
    state_nxt   = state;
    issue_first = 1'b0;
    issue_next  = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        // The first read leaves on the start edge, giving the 3-cycle latency.
        if (start) begin
          if (count != '0) begin
            issue_first = 1'b1;
            state_nxt   = (count == LOAD_SIZE'(1)) ? DRAIN : READ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      READ: begin
        if (remaining != '0 && credit) begin
          issue_next = 1'b1;
          if (remaining == LOAD_SIZE'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_nxt == 3'd0 && vld_pipe == 2'b00) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pulse or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      vld_pipe  <= '0;
      rd_addr   <= '0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      vld_pipe <= {vld_pipe[0], issue_first | issue_next};
      if (issue_first) begin
        rd_addr   <= LOAD_SIZE'(32'(base_addr) % 32'(MAX_LOCATIONS));
        remaining <= count - LOAD_SIZE'(1);
      end else if (issue_next) begin
        rd_addr   <= (rd_addr == LOAD_SIZE'(MAX_LOCATIONS - 1)) ? '0 : rd_addr + LOAD_SIZE'(1);
        remaining <= remaining - LOAD_SIZE'(1);
      end
      if (push) begin
        fifo[wr_ptr] <= rd_data;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ_nxt;
    end
  end

endmodule
